flip_game_engine: RTL and testbench
===================================

Name: flip_game_engine

Overview:
- Parametrised game core for the bit-flipping game: NUM_COLS falling columns, each carrying a random DATA_W-bit target value.
- The player matches a target on the switches to clear its column.
- Drop speed rises with score level; a life is lost whenever a column reaches the bottom.
- Sits between the switch inputs and the display/VGA and score/BCD paths. It replaces fixed per-column logic plus the separate top-level state machine.

Parameters:
- NUM_COLS, 3, number of columns.
- DATA_W, 8, target/switch width.
- YPOS_W, 5, row index width.
- ROW_LAST, 29, bottom row; a column at this row misses on its next drop tick.
- SCORE_W, 10, score width; the score saturates at all-ones.
- TICK_DIV, 5000000, clocks per drop tick at level 0.
- TICK_STEP, 500000, clocks removed from the tick period per level. Requires TICK_DIV > MAX_LEVEL*TICK_STEP.
- LEVEL_STEP, 10, correct hits per level increment.
- MAX_LEVEL, 7, level ceiling.
- LIVES, 3, lives per game (1..7).
- SPAWN_GAP, 6, minimum drop ticks between spawns.
- LFSR_SEED, 16'hACE1, non-zero seed for the 16-bit Galois LFSR (taps 16,14,13,11).

Ports:
- clock, in, 1, system clock.
- reset_signal, in, 1, synchronous active-high reset.
- start, in, 1, one-cycle pulse: begin a new game.
- pause, in, 1, one-cycle pulse: toggle pause.
- user_input, in, DATA_W, switch value.
- letters, out, NUM_COLS*DATA_W, target of column i at bits [i*DATA_W +: DATA_W].
- ypos, out, NUM_COLS*YPOS_W, row of column i.
- active, out, NUM_COLS, column i is falling.
- correct, out, NUM_COLS, one-cycle pulse: column i was matched.
- score, out, SCORE_W, correct hits this game.
- level, out, 3, current level.
- lives_left, out, 3, remaining lives.
- state, out, 2, 0=IDLE, 1=PLAY, 2=PAUSE, 3=OVER.

Behaviour:
- Reset (synchronous, highest priority):
  - state=IDLE; score, level and all correct/active/ypos/letters = 0; lives_left=LIVES.
  - LFSR=LFSR_SEED; prescaler=0; spawn counter=SPAWN_GAP so the first tick of a game spawns.
- State transitions:
  - IDLE --start--> PLAY.
  - PLAY --pause--> PAUSE; PAUSE --pause--> PLAY.
  - PLAY --lives reach 0--> OVER.
  - OVER --start--> PLAY.
  - start in PLAY or PAUSE is ignored. pause in IDLE or OVER is ignored.
- Entering PLAY from IDLE or OVER (the next cycle after start):
  - score=0, level=0, lives_left=LIVES, hit sub-counter=0, prescaler=0.
  - all columns inactive, spawn counter=SPAWN_GAP.
- LFSR: advances every clock in all states except during reset, so start timing seeds play.
- Prescaler (PLAY only; frozen in PAUSE, held at 0 elsewhere):
  - counts 0..(TICK_DIV - level*TICK_STEP - 1).
  - drop_tick is asserted on the terminal count, then the prescaler wraps to 0.
- Match (PLAY only, evaluated every cycle):
  - A column is hit if active and letters[i]==user_input.
  - Every hit column clears the same cycle: active=0, ypos=0, correct[i]=1 for one cycle.
  - score += popcount(hits), saturating.
  - A hit has priority over a drop/miss on the same cycle.
- Drop tick (PLAY), per active column not hit:
  - if ypos<ROW_LAST then ypos+1;
  - else the column clears and lives_left decrements.
  - Multiple simultaneous misses subtract their count, floored at 0.
  - If the result is 0, state=OVER on the next cycle and all columns clear.
- Spawn (on drop_tick):
  - spawn counter increments, saturating at SPAWN_GAP.
  - If it equals SPAWN_GAP and some column is inactive (before this tick's clears), the lowest-index inactive column becomes active.
  - New column: ypos=0, letters = LFSR[DATA_W-1:0]; if that value is 0, use 1. The spawn counter then resets to 0.
  - No inactive column: no spawn, and the counter stays saturated.
- Level:
  - The hit sub-counter adds popcount(hits).
  - On reaching or passing LEVEL_STEP it subtracts LEVEL_STEP, and level increments, saturating at MAX_LEVEL.
  - The new tick period applies from the next prescaler wrap.
- Pause and game over:
  - PAUSE freezes all columns, score, prescaler and matching; correct=0.
  - OVER holds score, level and letters for display; active=0.
- A reset asserted mid-game returns every output to its reset value on the next edge.

Decomposition:
- Package flip_game_pkg: state encoding constants, LFSR tap mask, lives/level widths.
- One natural sub-module, flip_column_slot: per-column active/ypos/letter registers.
  - Inputs: spawn, spawn_value, drop_tick, hit, clear_all.
  - Outputs: miss pulse, active, ypos, letter.
- The engine instantiates NUM_COLS slots in a generate loop and holds the FSM, prescaler, LFSR, spawn/level/score/lives logic.

Test Plan:
Sim params: TICK_DIV=8, TICK_STEP=1, SPAWN_GAP=2, ROW_LAST=3, LEVEL_STEP=2, LIVES=2.
- Reset, then start:
  - state=1 one cycle after start.
  - First drop_tick at clock 8 of PLAY; column 0 active, letter non-zero, ypos=0.
  - Column 1 spawns 2 ticks later.
- Drive user_input = letters of column 0:
  - correct[0] pulses 1 cycle; active[0]=0; score=1.
  - Set equal letters by forcing the LFSR: two columns match in one cycle, score +2, level=1, tick period 7.
- Leave column 0 unmatched:
  - After ticks to ypos=3 plus one more, it clears and lives_left 2→1.
  - Second miss: lives_left=0, state=3, active=0, score held.
- Pause mid-fall:
  - ypos, prescaler and score frozen for 50 cycles; matching user_input gives no correct.
  - A second pause resumes at the same ypos.
- Match and miss the same column on the same cycle (ypos=ROW_LAST on drop_tick): correct fires, lives unchanged.
- Assert reset_signal mid-PLAY: next edge gives state=0, score=0, lives_left=2, all active=0; start during OVER begins a fresh game.

Source files
------------

// File: rtl/flip_game_pkg.sv
// Shared types and constants for the bit-flipping game core.
package flip_game_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PLAY  = 2'd1,
    ST_PAUSE = 2'd2,
    ST_OVER  = 2'd3
  } game_state_t;

  // Right-shifting Galois form of the x^16+x^14+x^13+x^11+1 polynomial
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  localparam int unsigned LIVES_W   = 3;
  localparam int unsigned LEVEL_W   = 3;

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {1'b0, v[15:1]} ^ (v[0] ? LFSR_TAPS : 16'h0000);
  endfunction

endpackage

// File: rtl/flip_column_slot.sv
// One falling column: holds its active flag, row and target value.
module flip_column_slot #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned YPOS_W   = 5,
  parameter int unsigned ROW_LAST = 29
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              spawn,
  input  logic [DATA_W-1:0] spawn_value,
  input  logic              drop_tick,
  input  logic              hit,
  input  logic              clear_all,
  output logic              miss,
  output logic              active,
  output logic [YPOS_W-1:0] ypos,
  output logic [DATA_W-1:0] letter
);

  localparam logic [YPOS_W-1:0] ROW_LAST_P = YPOS_W'(ROW_LAST);

  // A hit on the bottom row wins over the miss
  assign miss = active && drop_tick && !hit && (ypos == ROW_LAST_P);

  always_ff @(posedge clk) begin
    if (rst) begin
      active <= 1'b0;
      ypos   <= '0;
      letter <= '0;
    end else if (clear_all || hit || miss) begin
      active <= 1'b0;
      ypos   <= '0;
    end else if (active) begin
      if (drop_tick) ypos <= ypos + 1'b1;
    end else if (spawn) begin
      active <= 1'b1;
      ypos   <= '0;
      letter <= spawn_value;
    end
  end

endmodule

// File: rtl/flip_game_engine.sv
// Game core: FSM, drop prescaler, LFSR spawner, score/level/lives, and column slots.
module flip_game_engine
  import flip_game_pkg::*;
#(
  parameter int unsigned NUM_COLS   = 3,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned YPOS_W     = 5,
  parameter int unsigned ROW_LAST   = 29,
  parameter int unsigned SCORE_W    = 10,
  parameter int unsigned TICK_DIV   = 5000000,
  parameter int unsigned TICK_STEP  = 500000,
  parameter int unsigned LEVEL_STEP = 10,
  parameter int unsigned MAX_LEVEL  = 7,
  parameter int unsigned LIVES      = 3,
  parameter int unsigned SPAWN_GAP  = 6,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic                       clock,
  input  logic                       reset_signal,
  input  logic                       start,
  input  logic                       pause,
  input  logic [DATA_W-1:0]          user_input,
  output logic [NUM_COLS*DATA_W-1:0] letters,
  output logic [NUM_COLS*YPOS_W-1:0] ypos,
  output logic [NUM_COLS-1:0]        active,
  output logic [NUM_COLS-1:0]        correct,
  output logic [SCORE_W-1:0]         score,
  output logic [2:0]                 level,
  output logic [2:0]                 lives_left,
  output logic [1:0]                 state
);

  localparam int unsigned PRESC_W = $clog2(TICK_DIV + 1);
  localparam int unsigned SUB_W   = $clog2(LEVEL_STEP + NUM_COLS + 1);
  localparam int unsigned GAP_W   = $clog2(SPAWN_GAP + 2);
  localparam int unsigned CNT_W   = $clog2(NUM_COLS + 1);

  localparam logic [PRESC_W-1:0] TICK_DIV_P  = PRESC_W'(TICK_DIV);
  localparam logic [PRESC_W-1:0] TICK_STEP_P = PRESC_W'(TICK_STEP);
  localparam logic [GAP_W-1:0]   GAP_P       = GAP_W'(SPAWN_GAP);
  localparam logic [SUB_W-1:0]   STEP_P      = SUB_W'(LEVEL_STEP);
  localparam logic [2:0]         MAX_LEVEL_P = 3'(MAX_LEVEL);
  localparam logic [2:0]         LIVES_P     = 3'(LIVES);
  localparam logic [SCORE_W-1:0] SCORE_ALL   = '1;

  game_state_t          st;
  logic [15:0]          lfsr;
  logic [PRESC_W-1:0]   presc, period;
  logic [GAP_W-1:0]     gap_cnt, gap_inc;
  logic [SUB_W-1:0]     hit_sub, sub_sum;
  logic [CNT_W-1:0]     hit_cnt, miss_cnt;
  logic [NUM_COLS-1:0]  hits, misses, spawn_vec;
  logic [DATA_W-1:0]    spawn_value;
  logic [2:0]           lives_after;
  logic [31:0]          score_sum;
  logic                 playing, drop_tick, spawn_fire, found;
  logic                 start_game, game_over_now, clear_all;

  assign state       = st;
  assign playing     = (st == ST_PLAY);
  assign drop_tick   = playing && (presc == period - 1'b1);
  assign start_game  = start && ((st == ST_IDLE) || (st == ST_OVER));
  assign spawn_value = (lfsr[DATA_W-1:0] == '0) ? DATA_W'(1) : lfsr[DATA_W-1:0];
  assign gap_inc     = (gap_cnt == GAP_P) ? GAP_P : gap_cnt + 1'b1;
  assign spawn_fire  = drop_tick && (gap_inc == GAP_P) && !(&active);

  always_comb begin
    hit_cnt   = '0;
    miss_cnt  = '0;
    spawn_vec = '0;
    found     = 1'b0;
    for (int unsigned i = 0; i < NUM_COLS; i++) begin
      hit_cnt  = hit_cnt + CNT_W'(hits[i]);
      miss_cnt = miss_cnt + CNT_W'(misses[i]);
      if (!active[i] && !found) begin
        spawn_vec[i] = spawn_fire;
        found        = 1'b1;
      end
    end
  end

  always_comb begin
    lives_after = '0;
    if (32'(lives_left) > 32'(miss_cnt)) lives_after = lives_left - 3'(miss_cnt);
    score_sum = 32'(score) + 32'(hit_cnt);
    sub_sum   = hit_sub + SUB_W'(hit_cnt);
  end

  // The column slots clear on game over so the missing column and its neighbours go together
  assign game_over_now = playing && (miss_cnt != '0) && (lives_after == '0);
  assign clear_all     = game_over_now || start_game;

  for (genvar i = 0; i < NUM_COLS; i++) begin : g_col
    assign hits[i] = playing && active[i] && (letters[i*DATA_W +: DATA_W] == user_input);

    flip_column_slot #(
      .DATA_W  (DATA_W),
      .YPOS_W  (YPOS_W),
      .ROW_LAST(ROW_LAST)
    ) u_slot (
      .clk        (clock),
      .rst        (reset_signal),
      .spawn      (spawn_vec[i]),
      .spawn_value(spawn_value),
      .drop_tick  (drop_tick),
      .hit        (hits[i]),
      .clear_all  (clear_all),
      .miss       (misses[i]),
      .active     (active[i]),
      .ypos       (ypos[i*YPOS_W +: YPOS_W]),
      .letter     (letters[i*DATA_W +: DATA_W])
    );
  end

  always_ff @(posedge clock) begin
    if (reset_signal) begin
      st         <= ST_IDLE;
      score      <= '0;
      level      <= '0;
      lives_left <= LIVES_P;
      correct    <= '0;
      lfsr       <= LFSR_SEED;
      presc      <= '0;
      period     <= TICK_DIV_P;
      gap_cnt    <= GAP_P;
      hit_sub    <= '0;
    end else begin
      lfsr    <= lfsr_step(lfsr);
      correct <= hits;
      case (st)
        ST_IDLE, ST_OVER: begin
          presc <= '0;
          if (start) begin
            st         <= ST_PLAY;
            score      <= '0;
            level      <= '0;
            lives_left <= LIVES_P;
            hit_sub    <= '0;
            gap_cnt    <= GAP_P;
            period     <= TICK_DIV_P;
          end
        end
        ST_PAUSE: begin
          if (pause) st <= ST_PLAY;
        end
        default: begin
          score      <= (score_sum > 32'(SCORE_ALL)) ? SCORE_ALL : SCORE_W'(score_sum);
          lives_left <= lives_after;
          if (sub_sum >= STEP_P) begin
            hit_sub <= sub_sum - STEP_P;
            if (level != MAX_LEVEL_P) level <= level + 1'b1;
          end else begin
            hit_sub <= sub_sum;
          end
          // Period is re-evaluated only at the wrap, so a level change never truncates a running count
          if (drop_tick) begin
            presc   <= '0;
            period  <= TICK_DIV_P - PRESC_W'(level) * TICK_STEP_P;
            gap_cnt <= spawn_fire ? '0 : gap_inc;
          end else begin
            presc <= presc + 1'b1;
          end
          if (game_over_now) st <= ST_OVER;
          else if (pause)    st <= ST_PAUSE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_flip_game_engine.sv
// Randomised self-checking bench for flip_game_engine against a cycle-level game model.
module tb_flip_game_engine;

  localparam int NC = 3, DW = 8, YW = 5, ROW_LAST = 3, GAP = 2, LSTEP = 2, LIVES = 2;
  localparam int TDIV = 8, TSTEP = 1, MAXLV = 7, SMAX = 1023;

  logic            clk = 1'b0;
  logic            rst_i = 1'b1, start_i = 1'b0, pause_i = 1'b0;
  logic [DW-1:0]   ui_i = '0;
  logic [NC*DW-1:0] letters;
  logic [NC*YW-1:0] ypos;
  logic [NC-1:0]   active, correct;
  logic [9:0]      score;
  logic [2:0]      level, lives_left;
  logic [1:0]      state;

  int tests = 0, fails = 0;

  // game model state
  int m_state, m_score, m_level, m_lives, m_sub, m_presc, m_period, m_gap;
  int m_act[NC], m_y[NC], m_let[NC], m_corr[NC];
  bit [15:0] m_lfsr;

  flip_game_engine #(
    .NUM_COLS(NC), .DATA_W(DW), .YPOS_W(YW), .ROW_LAST(ROW_LAST), .SCORE_W(10),
    .TICK_DIV(TDIV), .TICK_STEP(TSTEP), .LEVEL_STEP(LSTEP), .MAX_LEVEL(MAXLV),
    .LIVES(LIVES), .SPAWN_GAP(GAP), .LFSR_SEED(16'hACE1)
  ) dut (
    .clock(clk), .reset_signal(rst_i), .start(start_i), .pause(pause_i),
    .user_input(ui_i), .letters(letters), .ypos(ypos), .active(active),
    .correct(correct), .score(score), .level(level), .lives_left(lives_left),
    .state(state)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic model_step();
    int hit[NC];
    int nh, nm, tick, free_idx, old_level;
    bit [15:0] old_lfsr;
    for (int i = 0; i < NC; i++) m_corr[i] = 0;
    if (rst_i) begin
      m_state = 0; m_score = 0; m_level = 0; m_lives = LIVES; m_sub = 0;
      m_presc = 0; m_period = TDIV; m_gap = GAP; m_lfsr = 16'hACE1;
      for (int i = 0; i < NC; i++) begin m_act[i] = 0; m_y[i] = 0; m_let[i] = 0; end
      return;
    end
    old_lfsr = m_lfsr;
    m_lfsr = m_lfsr >> 1;
    if (old_lfsr[0]) m_lfsr = m_lfsr ^ 16'hB400;
    case (m_state)
      0, 3: if (start_i) begin
        m_state = 1; m_score = 0; m_level = 0; m_lives = LIVES; m_sub = 0;
        m_presc = 0; m_period = TDIV; m_gap = GAP;
        for (int i = 0; i < NC; i++) begin m_act[i] = 0; m_y[i] = 0; end
      end
      2: if (pause_i) m_state = 1;
      default: begin
        tick = (m_presc == m_period - 1);
        old_level = m_level;
        nh = 0; nm = 0; free_idx = -1;
        for (int i = 0; i < NC; i++) begin
          hit[i] = (m_act[i] != 0 && m_let[i] == int'(ui_i));
          nh += hit[i];
          if (m_act[i] == 0 && free_idx < 0) free_idx = i;
        end
        for (int i = 0; i < NC; i++) begin
          if (hit[i] != 0) begin
            m_act[i] = 0; m_y[i] = 0; m_corr[i] = 1;
          end else if (tick != 0 && m_act[i] != 0) begin
            if (m_y[i] < ROW_LAST) m_y[i]++;
            else begin m_act[i] = 0; m_y[i] = 0; nm++; end
          end
        end
        m_score = (m_score + nh > SMAX) ? SMAX : m_score + nh;
        m_sub += nh;
        if (m_sub >= LSTEP) begin
          m_sub -= LSTEP;
          if (m_level < MAXLV) m_level++;
        end
        m_lives = (nm >= m_lives) ? 0 : m_lives - nm;
        if (tick != 0) begin
          m_presc = 0;
          m_period = TDIV - old_level * TSTEP;
          m_gap = (m_gap + 1 > GAP) ? GAP : m_gap + 1;
        end else begin
          m_presc++;
        end
        if (nm > 0 && m_lives == 0) begin
          m_state = 3;
          for (int i = 0; i < NC; i++) begin m_act[i] = 0; m_y[i] = 0; end
        end else begin
          if (tick != 0 && m_gap == GAP && free_idx >= 0) begin
            m_act[free_idx] = 1; m_y[free_idx] = 0;
            m_let[free_idx] = (old_lfsr[7:0] == 0) ? 1 : int'(old_lfsr[7:0]);
            m_gap = 0;
          end
          if (pause_i) m_state = 2;
        end
      end
    endcase
  endtask

  function automatic logic [NC*DW-1:0] exp_letters();
    logic [NC*DW-1:0] r;
    for (int i = 0; i < NC; i++) r[i*DW +: DW] = DW'(m_let[i]);
    return r;
  endfunction

  function automatic logic [NC*YW-1:0] exp_ypos();
    logic [NC*YW-1:0] r;
    for (int i = 0; i < NC; i++) r[i*YW +: YW] = YW'(m_y[i]);
    return r;
  endfunction

  function automatic logic [NC-1:0] exp_vec(input int sel);
    logic [NC-1:0] r;
    for (int i = 0; i < NC; i++) r[i] = (sel == 0) ? (m_act[i] != 0) : (m_corr[i] != 0);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic pulse_start();
    start_i = 1'b1; tick(); start_i = 1'b0;
  endtask

  task automatic pulse_pause();
    pause_i = 1'b1; tick(); pause_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1; tick(); tick(); rst_i = 1'b0;
    tests++;
    if ({state, score, level, lives_left, active, correct} !== {2'd0, 10'd0, 3'd0, 3'd2, 3'b000, 3'b000}) begin
      fails++;
      $display("FAIL reset_state got st=%0d sc=%0d lv=%0d li=%0d act=%b cor=%b required 0 0 0 2 000 000",
               state, score, level, lives_left, active, correct);
    end
    tests++;
    if ({letters, ypos} !== '0) begin
      fails++;
      $display("FAIL reset_cols got letters=%h ypos=%h required 0", letters, ypos);
    end
  endtask

  task automatic test_start();
    ui_i = '0;
    pulse_start();
    tests++;
    if (state !== 2'd1) begin fails++; $display("FAIL start_state got %0d required 1", state); end
    repeat (7) tick();
    tests++;
    if (active !== 3'b000) begin fails++; $display("FAIL pre_tick_active got %b required 000", active); end
    tick();
    tests++;
    if (active !== 3'b001 || letters[7:0] === 8'd0 || ypos[4:0] !== 5'd0 || letters !== exp_letters()) begin
      fails++;
      $display("FAIL first_spawn got act=%b let=%h y=%h required act=001 let=%h y=0", active, letters, ypos, exp_letters());
    end
    repeat (15) tick();
    tests++;
    if (active !== 3'b001) begin fails++; $display("FAIL gap_hold got %b required 001", active); end
    tick();
    tests++;
    if (active !== 3'b011 || ypos[4:0] !== 5'd2) begin
      fails++; $display("FAIL second_spawn got act=%b y0=%0d required 011 2", active, ypos[4:0]);
    end
  endtask

  task automatic test_match();
    int exp_sc;
    ui_i = DW'(m_let[0]);
    tick();
    exp_sc = (m_let[0] == m_let[1]) ? 2 : 1;
    tests++;
    if (correct[0] !== 1'b1 || active[0] !== 1'b0 || score !== 10'(exp_sc)) begin
      fails++; $display("FAIL match_col0 got cor=%b act=%b sc=%0d required cor[0]=1 act[0]=0 sc=%0d", correct, active, score, exp_sc);
    end
    ui_i = '0;
    tick();
    tests++;
    if (correct !== 3'b000) begin fails++; $display("FAIL correct_pulse got %b required 000", correct); end
    if (m_act[1] != 0) begin
      ui_i = DW'(m_let[1]);
      tick();
      tests++;
      if (score !== 10'd2 || level !== 3'd1 || correct[1] !== 1'b1) begin
        fails++; $display("FAIL level_up got sc=%0d lv=%0d cor=%b required 2 1 cor[1]=1", score, level, correct);
      end
      ui_i = '0;
    end
  endtask

  task automatic test_miss();
    int sc_hold, n;
    ui_i = '0;
    n = 0;
    while (m_lives == LIVES && n < 300) begin tick(); n++; end
    tests++;
    if (n >= 300 || lives_left !== 3'd1 || active !== exp_vec(0)) begin
      fails++; $display("FAIL first_miss got li=%0d act=%b required 1 %b", lives_left, active, exp_vec(0));
    end
    sc_hold = m_score;
    n = 0;
    while (m_state != 3 && n < 300) begin tick(); n++; end
    tests++;
    if (n >= 300 || state !== 2'd3 || lives_left !== 3'd0 || active !== 3'b000 || score !== 10'(sc_hold)) begin
      fails++; $display("FAIL game_over got st=%0d li=%0d act=%b sc=%0d required 3 0 000 %0d", state, lives_left, active, score, sc_hold);
    end
    repeat (5) tick();
    tests++;
    if (state !== 2'd3 || score !== 10'(sc_hold)) begin
      fails++; $display("FAIL over_hold got st=%0d sc=%0d required 3 %0d", state, score, sc_hold);
    end
  endtask

  task automatic test_pause();
    int n;
    logic [NC*YW-1:0] y_hold;
    logic [9:0] s_hold;
    ui_i = '0;
    pulse_start();
    n = 0;
    while (!(m_act[0] != 0 && m_y[0] == 1) && n < 300) begin tick(); n++; end
    pulse_pause();
    tests++;
    if (n >= 300 || state !== 2'd2) begin fails++; $display("FAIL pause_enter got %0d required 2", state); end
    y_hold = exp_ypos();
    s_hold = 10'(m_score);
    ui_i = DW'(m_let[0]);
    for (int k = 0; k < 50; k++) begin
      tick();
      tests++;
      if (correct !== 3'b000 || ypos !== y_hold || score !== s_hold || state !== 2'd2) begin
        fails++; $display("FAIL pause_freeze got cor=%b y=%h sc=%0d st=%0d required 000 %h %0d 2", correct, ypos, score, state, y_hold, s_hold);
      end
    end
    pulse_pause();
    tests++;
    if (state !== 2'd1 || ypos[4:0] !== 5'd1 || active[0] !== 1'b1) begin
      fails++; $display("FAIL pause_resume got st=%0d y0=%0d act=%b required 1 1 act[0]=1", state, ypos[4:0], active);
    end
    tick();
    tests++;
    if (correct[0] !== 1'b1 || active[0] !== 1'b0) begin
      fails++; $display("FAIL resume_match got cor=%b act=%b required cor[0]=1 act[0]=0", correct, active);
    end
    ui_i = '0;
  endtask

  task automatic test_same_cycle();
    int n, idx, li, others;
    n = 0; idx = -1;
    ui_i = '0;
    while (idx < 0 && n < 400 && m_state == 1) begin
      tick(); n++;
      others = 0;
      for (int i = 0; i < NC; i++) if (m_act[i] != 0 && m_y[i] == ROW_LAST) others++;
      if (m_presc == m_period - 1 && others == 1)
        for (int i = 0; i < NC; i++) if (m_act[i] != 0 && m_y[i] == ROW_LAST) idx = i;
    end
    tests++;
    if (idx < 0) begin
      fails++; $display("FAIL same_cycle_setup got no candidate required one within 400 cycles");
    end else begin
      li = m_lives;
      ui_i = DW'(m_let[idx]);
      tick();
      ui_i = '0;
      tests++;
      if (correct[idx] !== 1'b1 || lives_left !== 3'(li) || active[idx] !== 1'b0) begin
        fails++; $display("FAIL hit_beats_miss got cor=%b li=%0d act=%b required cor[%0d]=1 li=%0d", correct, lives_left, active, idx, li);
      end
    end
  endtask

  task automatic test_random();
    logic [NC*DW-1:0] el;
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 1) == 0 && m_act[$urandom_range(0, NC-1)] != 0)
        ui_i = DW'(m_let[$urandom_range(0, NC-1)]);
      else if ($urandom_range(0, 3) == 0)
        ui_i = DW'($urandom);
      else
        ui_i = '0;
      start_i = ($urandom_range(0, 29) == 0);
      pause_i = ($urandom_range(0, 39) == 0);
      rst_i   = ($urandom_range(0, 499) == 0);
      tick();
      el = exp_letters();
      tests++;
      if ({state, score, level, lives_left} !== {2'(m_state), 10'(m_score), 3'(m_level), 3'(m_lives)} ||
          active !== exp_vec(0) || correct !== exp_vec(1) || ypos !== exp_ypos() || letters !== el) begin
        fails++;
        $display("FAIL random_cycle %0d got st=%0d sc=%0d lv=%0d li=%0d act=%b cor=%b y=%h let=%h required %0d %0d %0d %0d %b %b %h %h",
                 k, state, score, level, lives_left, active, correct, ypos, letters,
                 m_state, m_score, m_level, m_lives, exp_vec(0), exp_vec(1), exp_ypos(), el);
      end
    end
    start_i = 1'b0; pause_i = 1'b0; rst_i = 1'b0; ui_i = '0;
  endtask

  task automatic test_reset_midgame();
    int n;
    if (m_state == 2) pulse_pause();
    else if (m_state != 1) pulse_start();
    repeat (20) tick();
    rst_i = 1'b1; tick(); rst_i = 1'b0;
    tests++;
    if (state !== 2'd0 || score !== 10'd0 || lives_left !== 3'd2 || active !== 3'b000 || level !== 3'd0) begin
      fails++; $display("FAIL midgame_reset got st=%0d sc=%0d li=%0d act=%b lv=%0d required 0 0 2 000 0", state, score, lives_left, active, level);
    end
    pulse_start();
    n = 0;
    while (m_state != 3 && n < 600) begin tick(); n++; end
    tests++;
    if (state !== 2'd3) begin fails++; $display("FAIL reach_over got %0d required 3", state); end
    pulse_start();
    tests++;
    if (state !== 2'd1 || score !== 10'd0 || lives_left !== 3'd2 || active !== 3'b000) begin
      fails++; $display("FAIL restart got st=%0d sc=%0d li=%0d act=%b required 1 0 2 000", state, score, lives_left, active);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_start();
    test_match();
    test_miss();
    test_pause();
    test_same_cycle();
    test_random();
    test_reset_midgame();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
